// File: rtl/ota_trim_if.sv
// ---------------------------------------------------------------------------
// ota_trim_if
// Bundles the serial configuration and control signals of the OTA trim loader.
//   master : drives ena/start/sdi/sdi_valid/apply and observes the outputs
//   slave  : the loader itself
// Signals:
//   ena, start, sdi, sdi_valid, apply : control and serial frame input
//   trim_out [CHANNELS*TRIM_W]         : live trim bits, channel k at [k*TRIM_W +: TRIM_W]
//   busy, done, err, sdo               : frame status and shadow readback
// ---------------------------------------------------------------------------
interface ota_trim_if #(
    parameter int CHANNELS = 2,
    parameter int TRIM_W   = 6
);
    logic                         ena;
    logic                         start;
    logic                         sdi;
    logic                         sdi_valid;
    logic                         apply;
    logic [CHANNELS*TRIM_W-1:0]   trim_out;
    logic                         busy;
    logic                         done;
    logic                         err;
    logic                         sdo;

    modport master (
        output ena, start, sdi, sdi_valid, apply,
        input  trim_out, busy, done, err, sdo
    );

    modport slave (
        input  ena, start, sdi, sdi_valid, apply,
        output trim_out, busy, done, err, sdo
    );
endinterface

// File: rtl/ota_trim_loader.sv
// ---------------------------------------------------------------------------
// ota_trim_loader
// Bit-serial loader for the trim/mode bits of the analog OTA channels.
// A frame is HEADER(4) | index(IDX_W) | data(TRIM_W) | parity(1), MSB first,
// sampled on cycles with sdi_valid. Accepted words land in per-channel
// shadow registers; apply copies every shadow into trim_out in one edge so
// the analog bias never sees a half-written word.
// Ports:
//   clk   : tile clock
//   rst_n : asynchronous active-low reset
//   bus   : ota_trim_if.slave (ena, start, sdi, sdi_valid, apply,
//           trim_out, busy, done, err, sdo)
// ---------------------------------------------------------------------------
module ota_trim_loader #(
    parameter int                CHANNELS   = 2,
    parameter int                TRIM_W     = 6,
    parameter int                IDX_W      = 1,
    parameter logic [TRIM_W-1:0] RESET_TRIM = 6'b100000,
    parameter logic [3:0]        HEADER     = 4'b1010
) (
    input  logic        clk,
    input  logic        rst_n,
    ota_trim_if.slave   bus
);
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {IDLE, HDR, IDX, DATA, PAR} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             hdr_q, hdr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TRIM_W-1:0]      stage_q, stage_d;
    logic                   par_q, par_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   sdo_q, sdo_d;
    logic [TRIM_W-1:0]      shadow_q [CHANNELS];
    logic [TRIM_W-1:0]      shadow_d [CHANNELS];
    logic [CHANNELS*TRIM_W-1:0] trim_q, trim_d;

    // Shifted candidates; the extra MSB is dropped so width-1 fields work too.
    logic [3:0]             hdr_nxt;
    logic [IDX_W:0]         idx_sh;
    logic [IDX_W-1:0]       idx_nxt;
    logic [TRIM_W:0]        stage_sh;
    logic [TRIM_W-1:0]      stage_nxt;
    logic [TRIM_W-1:0]      old_word;
    logic [TRIM_W-1:0]      old_shift;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        par_d     = par_q;
        err_d     = err_q;
        done_d    = 1'b0;
        // Readback bit is held across sdi_valid gaps while still in DATA.
        sdo_d     = (state_q == DATA) ? sdo_q : 1'b0;
        shadow_d  = shadow_q;
        trim_d    = trim_q;

        hdr_nxt   = {hdr_q[2:0], bus.sdi};
        idx_sh    = {idx_q, bus.sdi};
        idx_nxt   = idx_sh[IDX_W-1:0];
        stage_sh  = {stage_q, bus.sdi};
        stage_nxt = stage_sh[TRIM_W-1:0];

        old_word  = shadow_q[0];
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx_q == IDX_W'(k)) old_word = shadow_q[k];
        end
        // MSB of the shifted word is the old shadow bit matching this data bit.
        old_shift = old_word << cnt_q;

        if (bus.ena && bus.start) begin
            state_d = HDR;
            cnt_d   = '0;
            err_d   = 1'b0;
            par_d   = 1'b0;
            sdo_d   = 1'b0;
        end else if (bus.ena && bus.sdi_valid) begin
            case (state_q)
                HDR: begin
                    hdr_d = hdr_nxt;
                    if (cnt_q == CNT_W'(3)) begin
                        cnt_d = '0;
                        if (hdr_nxt != HEADER) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = IDX;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                IDX: begin
                    idx_d = idx_nxt;
                    par_d = par_q ^ bus.sdi;
                    if (cnt_q == CNT_W'(IDX_W - 1)) begin
                        cnt_d = '0;
                        if (32'(idx_nxt) >= 32'(CHANNELS)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    stage_d = stage_nxt;
                    par_d   = par_q ^ bus.sdi;
                    sdo_d   = old_shift[TRIM_W-1];
                    if (cnt_q == CNT_W'(TRIM_W - 1)) begin
                        cnt_d   = '0;
                        state_d = PAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PAR: begin
                    state_d = IDLE;
                    if ((par_q ^ bus.sdi) == 1'b0) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (idx_q == IDX_W'(k)) shadow_d[k] = stage_q;
                        end
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Built from shadow_d so a word accepted this cycle is already included.
        if (bus.ena && bus.apply) begin
            for (int k = 0; k < CHANNELS; k++) begin
                trim_d[k*TRIM_W +: TRIM_W] = shadow_d[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            sdo_q   <= 1'b0;
            trim_q  <= {CHANNELS{RESET_TRIM}};
            for (int k = 0; k < CHANNELS; k++) shadow_q[k] <= RESET_TRIM;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            par_q   <= par_d;
            err_q   <= err_d;
            done_q  <= done_d;
            sdo_q   <= sdo_d;
            trim_q  <= trim_d;
            for (int k = 0; k < CHANNELS; k++) shadow_q[k] <= shadow_d[k];
        end
    end

    assign bus.trim_out = trim_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.sdo      = sdo_q;
endmodule

// File: tb/tb_ota_trim_loader.sv
// ---------------------------------------------------------------------------
// tb_ota_trim_loader
// Directed bench for ota_trim_loader: a default build (2 channels, 1-bit
// index) and a 3-channel build with a 2-bit index for the index range error.
// Stimulus is a linear sequence of directed steps; expected values are
// worked out by hand from the frame format.
// ---------------------------------------------------------------------------
module tb_ota_trim_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic ena, start, sdi, sdi_valid, apply;
    logic sel;   // 0: drive the default build, 1: drive the 3-channel build

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    ota_trim_if #(.CHANNELS(2), .TRIM_W(6)) a_if ();
    ota_trim_if #(.CHANNELS(3), .TRIM_W(6)) b_if ();

    assign a_if.ena       = ena;
    assign a_if.sdi       = sdi;
    assign a_if.start     = start     & ~sel;
    assign a_if.sdi_valid = sdi_valid & ~sel;
    assign a_if.apply     = apply     & ~sel;
    assign b_if.ena       = ena;
    assign b_if.sdi       = sdi;
    assign b_if.start     = start     & sel;
    assign b_if.sdi_valid = sdi_valid & sel;
    assign b_if.apply     = apply     & sel;

    ota_trim_loader #(
        .CHANNELS(2), .TRIM_W(6), .IDX_W(1),
        .RESET_TRIM(6'b100000), .HEADER(4'b1010)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    ota_trim_loader #(
        .CHANNELS(3), .TRIM_W(6), .IDX_W(2),
        .RESET_TRIM(6'b100000), .HEADER(4'b1010)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_if.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_apply();
        apply = 1'b1;
        tick();
        apply = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi       = v[i];
            sdi_valid = 1'b1;
            tick();
            sdi_valid = 1'b0;
        end
    endtask

    initial begin
        logic [11:0] frm;
        logic [5:0]  old0;
        int          d0;

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; sdi = 1'b0;
        sdi_valid = 1'b0; apply = 1'b0; sel = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_trim", 32'(a_if.trim_out), 32'h820);
        check("rst_busy", 32'(a_if.busy), 0);
        check("rst_err",  32'(a_if.err),  0);
        check("rst_done", 32'(a_if.done), 0);
        check("rst_sdo",  32'(a_if.sdo),  0);
        check("rst_trim_b", 32'(b_if.trim_out), 32'h20820);
        rst_n = 1'b1;
        tick();

        // Good frame: 1010 | 1 | 010111 | 1
        pulse_start();
        check("good_busy_hdr", 32'(a_if.busy), 1);
        send_bits(32'b1010_1_010111, 11);
        check("good_no_done_yet", 32'(a_if.done), 0);
        send_bits(32'b1, 1);
        check("good_done", 32'(a_if.done), 1);
        check("good_err",  32'(a_if.err),  0);
        check("good_idle", 32'(a_if.busy), 0);
        tick();
        check("good_done_1cyc", 32'(a_if.done), 0);
        check("good_trim_noapply", 32'(a_if.trim_out), 32'h820);
        pulse_apply();
        check("good_trim_apply", 32'(a_if.trim_out), 32'h5E0);

        // Reset mid-frame clears asynchronously
        pulse_start();
        send_bits(32'b10101, 5);
        #2 rst_n = 1'b0;
        #1;
        check("amid_trim", 32'(a_if.trim_out), 32'h820);
        check("amid_busy", 32'(a_if.busy), 0);
        check("amid_err",  32'(a_if.err),  0);
        check("amid_done", 32'(a_if.done), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Bad parity: same frame, parity 0
        d0 = done_cnt;
        pulse_start();
        send_bits(32'b1010_1_010111_0, 12);
        check("par_err",  32'(a_if.err),  1);
        check("par_busy", 32'(a_if.busy), 0);
        pulse_apply();
        check("par_nodone", 32'(done_cnt - d0), 0);
        check("par_trim", 32'(a_if.trim_out), 32'h820);
        check("par_err_sticky", 32'(a_if.err), 1);
        pulse_start();
        check("par_err_clr", 32'(a_if.err), 0);
        check("par_restart_busy", 32'(a_if.busy), 1);

        // Bad header 1011
        pulse_start();
        send_bits(32'b101, 3);
        check("hdr_err_pre", 32'(a_if.err), 0);
        send_bits(32'b1, 1);
        check("hdr_err",  32'(a_if.err),  1);
        check("hdr_busy", 32'(a_if.busy), 0);
        pulse_apply();
        check("hdr_trim", 32'(a_if.trim_out), 32'h820);

        // Index out of range on the 3-channel build
        sel = 1'b1;
        pulse_start();
        send_bits(32'b1010_1, 5);
        check("idx_err_pre",  32'(b_if.err),  0);
        check("idx_busy_pre", 32'(b_if.busy), 1);
        send_bits(32'b1, 1);
        check("idx_err",  32'(b_if.err),  1);
        check("idx_busy", 32'(b_if.busy), 0);
        pulse_apply();
        check("idx_trim_b", 32'(b_if.trim_out), 32'h20820);
        sel = 1'b0;

        // Restart mid-DATA; only the second frame (idx 0 = 000111) lands
        d0 = done_cnt;
        pulse_start();
        send_bits(32'b1010_1_010, 8);
        pulse_start();
        check("rs_err_clr", 32'(a_if.err), 0);
        send_bits(32'b1010_0_000111_1, 12);
        tick();
        check("rs_done_once", 32'(done_cnt - d0), 1);
        pulse_apply();
        check("rs_trim", 32'(a_if.trim_out), 32'h807);

        // Preload shadow0 with 101010
        pulse_start();
        send_bits(32'b1010_0_101010_1, 12);
        pulse_apply();
        check("pre_trim", 32'(a_if.trim_out), 32'h82A);

        // Gapped frame idx 0 = 110011, readback of old 101010, apply in PAR
        old0 = 6'b101010;
        frm  = 12'b1010_0_110011_0;
        pulse_start();
        for (int i = 11; i >= 0; i--) begin
            sdi       = frm[i];
            sdi_valid = 1'b1;
            apply     = (i == 0);
            tick();
            sdi_valid = 1'b0;
            apply     = 1'b0;
            if (i >= 1 && i <= 6) begin
                check($sformatf("gap_sdo_%0d", 6 - i), 32'(a_if.sdo), 32'(old0[i-1]));
            end
            if (i != 0) tick();
        end
        check("gap_done", 32'(a_if.done), 1);
        check("gap_trim", 32'(a_if.trim_out), 32'h833);
        check("gap_err",  32'(a_if.err), 0);
        tick();
        check("gap_sdo_idle", 32'(a_if.sdo), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
